// File: rtl/fd_spi_master_if.sv
// fd_spi_master_if: request/response handshake and SPI pins of the FD serial bus master
interface fd_spi_master_if;
  logic        start_i;
  logic [1:0]  cs_sel_i;
  logic [23:0] data_i;
  logic        ready_o;
  logic        done_o;
  logic [23:0] data_o;
  logic        spi_cs_dac_n_o;
  logic        spi_cs_pll_n_o;
  logic        spi_cs_gpio_n_o;
  logic        spi_sclk_o;
  logic        spi_mosi_o;
  logic        spi_miso_i;
  modport master (
    input  start_i, cs_sel_i, data_i, spi_miso_i,
    output ready_o, done_o, data_o, spi_cs_dac_n_o, spi_cs_pll_n_o, spi_cs_gpio_n_o,
           spi_sclk_o, spi_mosi_o
  );
  modport slave (
    output start_i, cs_sel_i, data_i, spi_miso_i,
    input  ready_o, done_o, data_o, spi_cs_dac_n_o, spi_cs_pll_n_o, spi_cs_gpio_n_o,
           spi_sclk_o, spi_mosi_o
  );
endinterface

// File: rtl/fd_spi_master.sv
// fd_spi_master: mode-0 SPI master sending one 24-bit frame per request to the FD DAC, PLL or GPIO expander
module fd_spi_master #(
  parameter int g_div        = 4,
  parameter int g_frame_bits = 24
) (
  input  logic            clk_sys_i,
  input  logic            rst_i,
  fd_spi_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FINISH} state_t;
  localparam logic [7:0] last  = 8'(g_div - 1);
  localparam logic [4:0] nbits = 5'(g_frame_bits);
  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [4:0]  bits, bits_n;
  logic [23:0] sh, sh_n, rx, rx_n, dout, dout_n;
  logic [2:0]  cs_n, cs_n_n;
  logic        sclk, sclk_n, mosi, mosi_n, ready, ready_n, done, done_n;
  logic        tick;
  assign tick = cnt == last;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 8'd1;
    bits_n  = bits;
    sh_n    = sh;
    rx_n    = rx;
    dout_n  = dout;
    cs_n_n  = cs_n;
    sclk_n  = sclk;
    mosi_n  = mosi;
    ready_n = ready;
    done_n  = 1'b0;
    case (state)
      IDLE: if (bus.start_i && ready) begin
        state_n = SETUP;
        cnt_n   = '0;
        bits_n  = '0;
        sh_n    = bus.data_i;
        rx_n    = '0;
        mosi_n  = bus.data_i[23];
        ready_n = 1'b0;
        cs_n_n  = ~(3'b001 << bus.cs_sel_i);
      end
      SETUP: if (tick) begin
        state_n = HIGH;
        cnt_n   = '0;
        sclk_n  = 1'b1;
      end
      HIGH: begin
        rx_n = (cnt == 8'd0) ? {rx[22:0], bus.spi_miso_i} : rx;
        if (tick) begin
          state_n = LOW;
          cnt_n   = '0;
          sclk_n  = 1'b0;
          bits_n  = bits + 5'd1;
          sh_n    = sh << 1;
          mosi_n  = (bits == nbits - 5'd1) ? mosi : sh[22];
        end
      end
      LOW: if (tick) begin
        cnt_n   = '0;
        state_n = (bits < nbits) ? HIGH : FINISH;
        sclk_n  = bits < nbits;
        if (bits >= nbits) begin
          cs_n_n = 3'b111;
          done_n = 1'b1;
          dout_n = rx;
          mosi_n = 1'b0;
        end
      end
      FINISH: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
      sh    <= '0;
      rx    <= '0;
      dout  <= '0;
      cs_n  <= 3'b111;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bits  <= bits_n;
      sh    <= sh_n;
      rx    <= rx_n;
      dout  <= dout_n;
      cs_n  <= cs_n_n;
      sclk  <= sclk_n;
      mosi  <= mosi_n;
      ready <= ready_n;
      done  <= done_n;
    end
  end
  assign bus.ready_o         = ready;
  assign bus.done_o          = done;
  assign bus.data_o          = dout;
  assign bus.spi_cs_dac_n_o  = cs_n[0];
  assign bus.spi_cs_pll_n_o  = cs_n[1];
  assign bus.spi_cs_gpio_n_o = cs_n[2];
  assign bus.spi_sclk_o      = sclk;
  assign bus.spi_mosi_o      = mosi;
endmodule

// File: tb/tb_fd_spi_master.sv
// tb_fd_spi_master: directed checks of fd_spi_master at g_div=4 and g_div=1 with loopback and GPIO slave models
module tb_fd_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st = 1'b0;
  logic use1 = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [23:0] dat = '0;
  int passed = 0;
  int total = 0;
  fd_spi_master_if a();
  fd_spi_master_if b();
  fd_spi_master #(.g_div(4)) u_a (.clk_sys_i(clk), .rst_i(rst), .bus(a));
  fd_spi_master #(.g_div(1)) u_b (.clk_sys_i(clk), .rst_i(rst), .bus(b));
  always #5 clk = ~clk;
  assign a.start_i    = st && !use1;
  assign b.start_i    = st && use1;
  assign a.cs_sel_i   = sel;
  assign b.cs_sel_i   = sel;
  assign a.data_i     = dat;
  assign b.data_i     = dat;
  assign a.spi_miso_i = a.spi_mosi_o;
  assign b.spi_miso_i = b.spi_mosi_o;
  wire [2:0]  cs_n  = use1 ? {b.spi_cs_gpio_n_o, b.spi_cs_pll_n_o, b.spi_cs_dac_n_o}
                           : {a.spi_cs_gpio_n_o, a.spi_cs_pll_n_o, a.spi_cs_dac_n_o};
  wire        sclk  = use1 ? b.spi_sclk_o : a.spi_sclk_o;
  wire        mosi  = use1 ? b.spi_mosi_o : a.spi_mosi_o;
  wire        ready = use1 ? b.ready_o : a.ready_o;
  wire        done  = use1 ? b.done_o : a.done_o;
  wire [23:0] dout  = use1 ? b.data_o : a.data_o;
  // GPIO expander: shifts on sclk rise, latches low byte on CS rise only after a whole 24-bit frame
  logic [23:0] sr_a = '0, sr_b = '0;
  logic [7:0]  gpio_a = '0, gpio_b = '0;
  int          nb_a = 0, nb_b = 0;
  always @(posedge a.spi_sclk_o or posedge a.spi_cs_gpio_n_o)
    if (a.spi_cs_gpio_n_o) begin
      if (nb_a == 24) gpio_a <= sr_a[7:0];
      nb_a <= 0;
    end else begin
      sr_a <= {sr_a[22:0], a.spi_mosi_o};
      nb_a <= nb_a + 1;
    end
  always @(posedge b.spi_sclk_o or posedge b.spi_cs_gpio_n_o)
    if (b.spi_cs_gpio_n_o) begin
      if (nb_b == 24) gpio_b <= sr_b[7:0];
      nb_b <= 0;
    end else begin
      sr_b <= {sr_b[22:0], b.spi_mosi_o};
      nb_b <= nb_b + 1;
    end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [1:0] s, input logic [23:0] d);
    for (int k = 0; k < 10 && !ready; k++) step();
    check("ready_before_start", 32'(ready), 32'd1);
    sel = s;
    dat = d;
    st  = 1'b1;
  endtask
  task automatic watch(input int mid, output int lat, output int lo_d, output int lo_p,
                       output int lo_g, output int rises, output int multi,
                       output bit first_low, output logic [23:0] rx);
    logic pv;
    int n;
    bit seen;
    lo_d = 0; lo_p = 0; lo_g = 0; rises = 0; multi = 0; n = 0; seen = 0;
    first_low = 0; rx = 'x; pv = sclk;
    while (!seen && n < 400) begin
      step();
      n++;
      st = (mid != 0 && n == mid);
      if (n == 1) first_low = cs_n != 3'b111;
      lo_d += int'(!cs_n[0]);
      lo_p += int'(!cs_n[1]);
      lo_g += int'(!cs_n[2]);
      if ($countones(~cs_n) > 1) multi++;
      if (sclk && !pv) rises++;
      pv = sclk;
      if (done) begin
        seen = 1;
        rx = dout;
      end
    end
    lat = seen ? n : -1;
  endtask
  initial begin
    int lat, ld, lp, lg, rs, mu, gap, nd;
    bit fl;
    logic [23:0] rx;
    step();
    step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data_o", 32'(dout), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'h7);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ready_g1", 32'(b.ready_o), 32'd1);
    rst = 1'b0;
    step();
    go(2'd2, 24'h0000A5);
    watch(0, lat, ld, lp, lg, rs, mu, fl, rx);
    check("gpio_latency", 32'(lat), 32'd197);
    check("gpio_cs_low", 32'(lg), 32'd196);
    check("gpio_other_cs", 32'(ld + lp), 32'd0);
    check("gpio_sclk_rises", 32'(rs), 32'd24);
    check("gpio_value", 32'(gpio_a), 32'hA5);
    check("finish_cs_high", 32'(cs_n), 32'h7);
    check("finish_mosi", 32'(mosi), 32'd0);
    go(2'd1, 24'h5A3C96);
    watch(0, lat, ld, lp, lg, rs, mu, fl, rx);
    check("loop_data", 32'(rx), 32'h5A3C96);
    check("loop_pll_low", 32'(lp), 32'd196);
    check("loop_other_cs", 32'(ld + lg), 32'd0);
    go(2'd0, 24'h123456);
    watch(0, lat, ld, lp, lg, rs, mu, fl, rx);
    check("dac_low", 32'(ld), 32'd196);
    check("dac_other_cs", 32'(lp + lg), 32'd0);
    check("dac_data", 32'(rx), 32'h123456);
    go(2'd3, 24'h00F00F);
    watch(0, lat, ld, lp, lg, rs, mu, fl, rx);
    check("dummy_no_cs", 32'(ld + lp + lg), 32'd0);
    check("dummy_rises", 32'(rs), 32'd24);
    check("dummy_done", 32'(lat), 32'd197);
    check("dummy_data", 32'(rx), 32'h00F00F);
    go(2'd2, 24'h0000C3);
    watch(50, lat, ld, lp, lg, rs, mu, fl, rx);
    check("busy_latency", 32'(lat), 32'd197);
    check("busy_data", 32'(rx), 32'h0000C3);
    check("busy_overlap", 32'(mu), 32'd0);
    check("busy_gpio", 32'(gpio_a), 32'hC3);
    for (int k = 0; k < 4; k++) step();
    check("busy_not_queued_cs", 32'(cs_n), 32'h7);
    check("busy_not_queued_ready", 32'(ready), 32'd1);
    go(2'd1, 24'hABCDEF);
    watch(0, lat, ld, lp, lg, rs, mu, fl, rx);
    gap = 1;
    for (int k = 0; k < 10 && !ready; k++) begin
      step();
      gap++;
      check("b2b_gap_cs_high", 32'(cs_n), 32'h7);
    end
    check("b2b_gap", 32'(gap), 32'd2);
    sel = 2'd1;
    dat = 24'h13579B;
    st  = 1'b1;
    watch(0, lat, ld, lp, lg, rs, mu, fl, rx);
    check("b2b_first_low", 32'(fl), 32'd1);
    check("b2b_data", 32'(rx), 32'h13579B);
    go(2'd2, 24'h000055);
    rs = 0;
    for (int k = 0; k < 200 && rs < 10; k++) begin
      logic pv;
      pv = sclk;
      step();
      st = 1'b0;
      if (sclk && !pv) rs++;
    end
    check("rst_mid_reached", 32'(rs), 32'd10);
    rst = 1'b1;
    step();
    check("rst_mid_cs", 32'(cs_n), 32'h7);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_data_o", 32'(dout), 32'd0);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      nd += int'(done);
    end
    check("rst_mid_no_done", 32'(nd), 32'd0);
    check("rst_mid_gpio", 32'(gpio_a), 32'hC3);
    use1 = 1'b1;
    go(2'd2, 24'hFFFF3C);
    watch(0, lat, ld, lp, lg, rs, mu, fl, rx);
    check("div1_latency", 32'(lat), 32'd50);
    check("div1_cs_low", 32'(lg), 32'd49);
    check("div1_rises", 32'(rs), 32'd24);
    check("div1_gpio", 32'(gpio_b), 32'h3C);
    check("div1_data", 32'(rx), 32'hFFFF3C);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
